mem_arbiter: RTL and testbench

- Parametrised successor to the two-port memory mux.
- Arbitrates NUM_PORTS requesters (icache, LSB, future dcache/prefetch) onto the single byte-wide RAM port.
- Uses round-robin fairness and performs multi-byte (1/2/4 B) little-endian transfers as a sequenced burst.
- Stalls I/O writes while the I/O buffer is full.
- Sits between the requesters and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-wide RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_TAIL  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Transfer size encodings carried on req_size.
  localparam logic [1:0] SIZE_1B     = 2'b00;
  localparam logic [1:0] SIZE_2B     = 2'b01;
  localparam logic [1:0] SIZE_4B     = 2'b10;
  localparam logic [1:0] SIZE_4B_ALT = 2'b11;

  // addr[17:16] value that marks the I/O region.
  localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

  // Number of bytes moved for a given size code.
  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_1B:     return 3'd1;
      SIZE_2B:     return 3'd2;
      SIZE_4B:     return 3'd4;
      SIZE_4B_ALT: return 3'd4;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: grants the first valid port after last_grant, wrapping.
module mem_arbiter_rr_picker #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic found;

  // Scan ports starting just after last_grant so the last winner is checked last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int cand;
      cand = (int'(last_grant) + i) % NUM_PORTS;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one byte-wide RAM port, sequencing
// 1/2/4-byte little-endian transfers and stalling I/O writes on a full buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         NUM_PORTS  = 2,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT,
  localparam int        IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*2-1:0]           req_size,
  input  logic [NUM_PORTS*32-1:0]          req_wdata,
  output logic [NUM_PORTS-1:0]             resp_done,
  output logic [31:0]                      resp_rdata,
  input  logic [7:0]                       mem_din,
  output logic [7:0]                       mem_dout,
  output logic [ADDR_WIDTH-1:0]            mem_a,
  output logic                             mem_wr,
  input  logic                             io_buffer_full
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       port_q, port_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [2:0]             nbytes_q, nbytes_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rd_pend_q, rd_pend_d;

  logic [NUM_PORTS-1:0]   grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [1:0]             cap_idx;
  logic                   io_stall;

  mem_arbiter_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign cur_addr = addr_q + ADDR_WIDTH'(cnt_q);
  // The byte arriving now belongs to the address issued last cycle (cnt-1).
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign io_stall = wr_q && io_buffer_full && (cur_addr[17:16] == IO_ADDR_HI);

  // Next-state, datapath updates and all outputs, derived from registered state.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_pend_d  = (state_q == ST_ISSUE) && !wr_q;
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    resp_done  = '0;
    resp_rdata = '0;

    if (rd_pend_q) rdata_d[8*cap_idx +: 8] = mem_din;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          port_d   = grant_idx;
          addr_d   = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wr_d     = req_wr[grant_idx];
          nbytes_d = size_to_nbytes(req_size[grant_idx*2 +: 2]);
          wdata_d  = req_wdata[grant_idx*32 +: 32];
          rdata_d  = '0;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_a = cur_addr;
        if (wr_q) begin
          mem_dout = wdata_q[8*cnt_q[1:0] +: 8];
          mem_wr   = !io_stall;
        end
        if (!io_stall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == nbytes_q - 3'd1) state_d = wr_q ? ST_RESP : ST_TAIL;
        end
      end
      ST_TAIL: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_done[port_q] = 1'b1;
        resp_rdata        = rdata_q;
        last_d            = port_q;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      last_q    <= IDX_W'(NUM_PORTS - 1);
      addr_q    <= '0;
      wr_q      <= 1'b0;
      nbytes_q  <= 3'd1;
      cnt_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      port_q    <= port_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      nbytes_q  <= nbytes_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic [1:0]  resp_done;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:511];
  int          tests = 0;
  int          fails = 0;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_wdata      (req_wdata),
    .resp_done      (resp_done),
    .resp_rdata     (resp_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM read port: byte for the address seen at an edge appears the next cycle.
  always @(posedge clk_in) mem_din <= ram[mem_a[8:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
    req_wr[p]             = wr;
    req_addr[p*32 +: 32]  = addr;
    req_size[p*2 +: 2]    = size;
    req_wdata[p*32 +: 32] = wdata;
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[9'h100] = 8'h11; ram[9'h101] = 8'h22; ram[9'h102] = 8'h33; ram[9'h103] = 8'h44;
    ram[9'h007] = 8'hBE; ram[9'h008] = 8'hEF;
    ram[9'h010] = 8'h5A; ram[9'h020] = 8'hC3;
    rst_in = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0;
    req_size = '0; req_wdata = '0; io_buffer_full = 1'b0;

    // Reset values.
    repeat (2) cyc();
    check("rst_resp_done", 32'(resp_done), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    rst_in = 1'b1;
    cyc();

    // Port1 4 B read at 0x100; its address changes mid-burst and must be ignored.
    set_req(1, 1'b0, 32'h100, 2'b10, 32'h0);
    req_valid = 2'b10;
    cyc();
    set_req(1, 1'b0, 32'h1F0, 2'b00, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd4_mem_a%0d", k), mem_a, 32'h100 + 32'(k));
      check($sformatf("rd4_mem_wr%0d", k), 32'(mem_wr), 32'h0);
      cyc();
    end
    check("rd4_tail_done", 32'(resp_done), 32'h0);
    check("rd4_tail_mem_a", mem_a, 32'h0);
    cyc();
    check("rd4_done", 32'(resp_done), 32'h2);
    check("rd4_rdata", resp_rdata, 32'h44332211);
    req_valid = 2'b00;
    cyc();
    check("rd4_done_clear", 32'(resp_done), 32'h0);

    // Port0 2 B read at 0x7; upper bytes must be zero.
    set_req(0, 1'b0, 32'h7, 2'b01, 32'h0);
    req_valid = 2'b01;
    cyc();
    check("rd2_mem_a0", mem_a, 32'h7);
    cyc();
    check("rd2_mem_a1", mem_a, 32'h8);
    cyc();
    check("rd2_tail_done", 32'(resp_done), 32'h0);
    cyc();
    check("rd2_done", 32'(resp_done), 32'h1);
    check("rd2_rdata", resp_rdata, 32'h0000EFBE);
    req_valid = 2'b00;
    cyc();

    // Port0 1 B I/O write stalled for 3 cycles by a full buffer.
    set_req(0, 1'b1, 32'h30000, 2'b00, 32'h000000A5);
    io_buffer_full = 1'b1;
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("io_stall_wr%0d", k), 32'(mem_wr), 32'h0);
      check($sformatf("io_stall_a%0d", k), mem_a, 32'h30000);
      check($sformatf("io_stall_done%0d", k), 32'(resp_done), 32'h0);
    end
    cyc();
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", 32'(mem_wr), 32'h1);
    check("io_dout", 32'(mem_dout), 32'hA5);
    cyc();
    check("io_done", 32'(resp_done), 32'h1);
    req_valid = 2'b00;
    cyc();

    // Port1 2 B write outside the I/O region is not stalled by a full buffer.
    set_req(1, 1'b1, 32'h40, 2'b01, 32'h00001234);
    io_buffer_full = 1'b1;
    req_valid = 2'b10;
    cyc();
    check("mem_wr0", 32'(mem_wr), 32'h1);
    check("mem_wr0_a", mem_a, 32'h40);
    check("mem_wr0_dout", 32'(mem_dout), 32'h34);
    cyc();
    check("mem_wr1", 32'(mem_wr), 32'h1);
    check("mem_wr1_a", mem_a, 32'h41);
    check("mem_wr1_dout", 32'(mem_dout), 32'h12);
    cyc();
    check("mem_wr_done", 32'(resp_done), 32'h2);
    req_valid = 2'b00;
    io_buffer_full = 1'b0;
    cyc();

    // Both ports request continuously; grants must alternate 0,1,0,1.
    set_req(0, 1'b0, 32'h10, 2'b00, 32'h0);
    set_req(1, 1'b0, 32'h20, 2'b00, 32'h0);
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      cyc();
      if (resp_done != 2'b00) begin
        check($sformatf("rr_grant%0d", n), 32'(resp_done), (n % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("rr_rdata%0d", n), resp_rdata, (n % 2 == 0) ? 32'h5A : 32'hC3);
        n++;
        if (n == 4) req_valid = 2'b00;
      end
    end
    check("rr_count", 32'(n), 32'd4);
    cyc();

    // Reset during a 4 B write after two bytes: no response, clean restart.
    set_req(0, 1'b1, 32'h200, 2'b10, 32'hDDCCBBAA);
    req_valid = 2'b01;
    cyc();
    check("rstw_dout0", 32'(mem_dout), 32'hAA);
    cyc();
    check("rstw_dout1", 32'(mem_dout), 32'hBB);
    check("rstw_a1", mem_a, 32'h201);
    cyc();
    rst_in = 1'b0;
    req_valid = 2'b00;
    #1;
    check("rstw_mem_wr", 32'(mem_wr), 32'h0);
    check("rstw_mem_a", mem_a, 32'h0);
    check("rstw_mem_dout", 32'(mem_dout), 32'h0);
    cyc();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("rstw_no_done%0d", k), 32'(resp_done), 32'h0);
      check($sformatf("rstw_no_wr%0d", k), 32'(mem_wr), 32'h0);
    end
    set_req(0, 1'b0, 32'h7, 2'b00, 32'h0);
    set_req(1, 1'b0, 32'h20, 2'b00, 32'h0);
    req_valid = 2'b11;
    cyc();
    check("post_rst_port0_a", mem_a, 32'h7);
    cyc();
    cyc();
    check("post_rst_done", 32'(resp_done), 32'h1);
    check("post_rst_rdata", resp_rdata, 32'hBE);
    req_valid = 2'b00;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
